// File: rtl/si_shoot_pkg.sv
// Shared types and defaults for the player-bullet shoot controller.
package si_shoot_pkg;

    localparam int ROWS_DEFAULT     = 7;
    localparam int COLS_DEFAULT     = 8;
    localparam int TICK_DIV_DEFAULT = 2500000;
    // Short shift period so benches finish quickly
    localparam int TICK_DIV_SIM     = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        FLY    = 3'd2,
        SHIFT  = 3'd3,
        CLEAR  = 3'd4
    } shoot_state_t;

endpackage

// File: rtl/si_shoot_controller_tick.sv
// si_tick_divider: enabled up-counter with sync clear; pulses o_tc on the last count of each period.
module si_tick_divider #(
    parameter int TICK_DIV = 4,
    localparam int CNT_W   = $clog2(TICK_DIV)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == CNT_W'(TICK_DIV - 1));
    assign o_tc   = i_en && w_last;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/si_shoot_controller.sv
// Sequences the player-bullet shoot register: launch into row 1, paced upward shifts, retire or clear.
// Build option SI_SHOOT_FIRE_BUFFER_EN adds a one-entry pending-fire buffer captured while busy.
//
// state  | meaning
// IDLE   | no bullet; waiting for an enabled fire request
// LAUNCH | Load strobe with the one-hot column into row 1
// FLY    | bullet resting; tick divider counting toward the next shift
// SHIFT  | Load strobe with zero data, bullet moves up one row
// CLEAR  | Clear strobe after a hit; column wiped
module si_shoot_controller
    import si_shoot_pkg::*;
#(
    parameter int ROWS     = ROWS_DEFAULT,
    parameter int COLS     = COLS_DEFAULT,
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int COL_W    = $clog2(COLS),
    parameter int ROW_W    = $clog2(ROWS + 1)
) (
    input  logic             SI_SHOOT_CTRL_CLOCK_50,
    input  logic             SI_SHOOT_CTRL_RESET_InHigh,
    input  logic             SI_SHOOT_CTRL_Enable_InHigh,
    input  logic             SI_SHOOT_CTRL_Fire_InHigh,
    input  logic [COL_W-1:0] SI_SHOOT_CTRL_Column_InBus,
    input  logic             SI_SHOOT_CTRL_Hit_InHigh,
    output logic             SI_SHOOT_CTRL_Load_OutLow,
    output logic             SI_SHOOT_CTRL_Clear_OutLow,
    output logic [COLS-1:0]  SI_SHOOT_CTRL_DataIn_OutBus,
    output logic [ROW_W-1:0] SI_SHOOT_CTRL_Row_OutBus,
    output logic             SI_SHOOT_CTRL_Busy_OutHigh,
    output logic             SI_SHOOT_CTRL_Done_OutHigh
);

    shoot_state_t     r_state;
    shoot_state_t     w_next_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_done;

    logic             w_busy;
    logic             w_fire_ok;
    logic             w_tc;
    logic             w_top_row;
    logic [COL_W-1:0] w_col_sat;
    logic [COLS-1:0]  w_onehot;
    logic             w_pend_valid;
    logic [COL_W-1:0] w_pend_col;

    assign w_busy    = (r_state == LAUNCH) || (r_state == FLY) || (r_state == SHIFT);
    assign w_fire_ok = SI_SHOOT_CTRL_Fire_InHigh && SI_SHOOT_CTRL_Enable_InHigh;
    assign w_top_row = (r_row == ROW_W'(ROWS));
    assign w_col_sat = (32'(SI_SHOOT_CTRL_Column_InBus) >= COLS) ? COL_W'(COLS - 1)
                                                               : SI_SHOOT_CTRL_Column_InBus;
    assign w_onehot  = COLS'(1) << r_col;

    // Counter runs from LAUNCH onward so each LAUNCH/SHIFT cycle is part of its own period
    si_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk (SI_SHOOT_CTRL_CLOCK_50),
        .i_rst (SI_SHOOT_CTRL_RESET_InHigh),
        .i_en  (SI_SHOOT_CTRL_Enable_InHigh && w_busy),
        .i_clr ((r_state == IDLE) || (r_state == CLEAR)),
        .o_tc  (w_tc)
    );

`ifdef SI_SHOOT_FIRE_BUFFER_EN
    logic             r_pend_valid;
    logic [COL_W-1:0] r_pend_col;

    always_ff @(posedge SI_SHOOT_CTRL_CLOCK_50) begin
        if (SI_SHOOT_CTRL_RESET_InHigh || (r_state == CLEAR)) begin
            r_pend_valid <= 1'b0;
            r_pend_col   <= '0;
        end else if (w_busy && w_fire_ok) begin
            r_pend_valid <= 1'b1;
            r_pend_col   <= w_col_sat;
        end else if (r_state == IDLE) begin
            r_pend_valid <= 1'b0;
        end
    end

    assign w_pend_valid = r_pend_valid;
    assign w_pend_col   = r_pend_col;
`else
    assign w_pend_valid = 1'b0;
    assign w_pend_col   = '0;
`endif

    always_ff @(posedge SI_SHOOT_CTRL_CLOCK_50) begin
        if (SI_SHOOT_CTRL_RESET_InHigh) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pend_valid || w_fire_ok) w_next_state = LAUNCH;
            LAUNCH:  w_next_state = SI_SHOOT_CTRL_Hit_InHigh ? CLEAR : FLY;
            FLY: begin
                if (SI_SHOOT_CTRL_Hit_InHigh) w_next_state = CLEAR;
                else if (w_tc)                w_next_state = SHIFT;
            end
            // A hit during SHIFT still lets the shift land, then clears
            SHIFT: begin
                if (SI_SHOOT_CTRL_Hit_InHigh) w_next_state = CLEAR;
                else if (w_top_row)           w_next_state = IDLE;
                else                          w_next_state = FLY;
            end
            CLEAR:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge SI_SHOOT_CTRL_CLOCK_50) begin
        if (SI_SHOOT_CTRL_RESET_InHigh) begin
            r_col  <= '0;
            r_row  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_next_state == LAUNCH) begin
                        r_col <= w_pend_valid ? w_pend_col : w_col_sat;
                        r_row <= ROW_W'(1);
                    end
                end
                SHIFT: begin
                    r_row  <= w_top_row ? '0 : r_row + ROW_W'(1);
                    r_done <= (w_next_state == IDLE);
                end
                CLEAR: begin
                    r_row  <= '0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign SI_SHOOT_CTRL_Load_OutLow   = ~((r_state == LAUNCH) || (r_state == SHIFT));
    assign SI_SHOOT_CTRL_Clear_OutLow  = ~(r_state == CLEAR);
    assign SI_SHOOT_CTRL_DataIn_OutBus = (r_state == LAUNCH) ? w_onehot : '0;
    assign SI_SHOOT_CTRL_Row_OutBus    = r_row;
    assign SI_SHOOT_CTRL_Busy_OutHigh  = w_busy;
    assign SI_SHOOT_CTRL_Done_OutHigh  = r_done;

endmodule
